// File: rtl/unified_mem_responder.sv
// Unified instruction/data memory responder for the multicycle core.
// Word-addressed storage with combinational read and synchronous write,
// plus a boot loader that fills memory from a valid/ready word stream
// while holding the core in reset.
//
// Loader handshake: a word transfers on a rising edge where LoadValid and
// LoadReady are both high. LoadReady depends only on state, never on
// LoadValid. The first word is the length; the following words are data.
module unified_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6,
    parameter bit BOOT_LOAD   = 1'b1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    input  logic        LoadValid,
    input  logic [31:0] LoadData,
    output logic        LoadReady,
    output logic        CpuReset,
    output logic        AccessFault,
    output logic        MisalignFault,
    output logic        LoadDone
);

    localparam logic [1:0] LOAD_LEN  = 2'd0;
    localparam logic [1:0] LOAD_DATA = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    localparam logic [1:0]      RESET_STATE = BOOT_LOAD ? LOAD_LEN : RUN;
    localparam logic [ADDR_W:0] DEPTH_L     = (ADDR_W + 1)'(DEPTH_WORDS);
    localparam logic [ADDR_W:0] LEN_ONE     = (ADDR_W + 1)'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   len;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              misaligned;
    logic              handshake;
    logic [ADDR_W:0]   len_clamped;
    logic              last_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [31:0]       mem_wd;

    // Address decode and loader stream helpers.
    always_comb begin
        in_range    = (Adr[31:ADDR_W+2] == '0);
        idx         = Adr[ADDR_W+1:2];
        misaligned  = (Adr[1:0] != 2'b00);
        handshake   = LoadValid && LoadReady;
        len_clamped = (LoadData >= 32'(DEPTH_WORDS)) ? DEPTH_L : LoadData[ADDR_W:0];
        last_word   = ({1'b0, ptr} == (len - LEN_ONE));
    end

    // State-decoded status outputs.
    always_comb begin
        LoadReady = (state == LOAD_LEN) || (state == LOAD_DATA);
        CpuReset  = (state == LOAD_LEN) || (state == LOAD_DATA);
        LoadDone  = (state == RUN);
    end

    // Loader FSM, pointer, length and sticky fault flags.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state         <= RESET_STATE;
            ptr           <= '0;
            len           <= '0;
            AccessFault   <= 1'b0;
            MisalignFault <= 1'b0;
        end else begin
            case (state)
                LOAD_LEN: begin
                    if (handshake) begin
                        len   <= len_clamped;
                        state <= (len_clamped == '0) ? RUN : LOAD_DATA;
                    end
                end
                LOAD_DATA: begin
                    if (handshake) begin
                        ptr <= ptr + 1'b1;
                        if (last_word) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!in_range) begin
                        AccessFault <= 1'b1;
                    end
                    if (misaligned) begin
                        MisalignFault <= 1'b1;
                    end
                end
                default: state <= RESET_STATE;
            endcase
        end
    end

    // Single write port shared by the loader and core stores.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = ptr;
        mem_wd = LoadData;
        if ((state == LOAD_DATA) && handshake) begin
            mem_we = 1'b1;
        end else if ((state == RUN) && MemWrite && in_range) begin
            mem_we = 1'b1;
            mem_wa = idx;
            mem_wd = WriteData;
        end
    end

    // Storage is never cleared, so a partial load survives Reset.
    always_ff @(posedge clk) begin
        if (mem_we && !Reset) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Combinational read; out-of-range addresses return zero.
    always_comb begin
        ReadData = in_range ? mem[idx] : 32'h0;
    end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench for unified_mem_responder (DEPTH 64, boot load on).
// A behavioural model tracks memory contents, load progress and faults;
// one process compares every output against it each cycle, and directed
// steps pin the model with hand-computed literals.
module tb_unified_mem_responder;

    logic        clk;
    logic        Reset;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        LoadValid;
    logic [31:0] LoadData;
    logic        LoadReady;
    logic        CpuReset;
    logic        AccessFault;
    logic        MisalignFault;
    logic        LoadDone;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Behavioural model state.
    logic [31:0] m_mem [64];
    bit          m_known [64];
    bit          m_run;
    bit          m_wait_len;
    int          m_remaining;
    int          m_ptr;
    bit          m_af;
    bit          m_mf;

    unified_mem_responder #(
        .DEPTH_WORDS(64),
        .ADDR_W(6),
        .BOOT_LOAD(1'b1)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .Adr(Adr),
        .WriteData(WriteData),
        .MemWrite(MemWrite),
        .ReadData(ReadData),
        .LoadValid(LoadValid),
        .LoadData(LoadData),
        .LoadReady(LoadReady),
        .CpuReset(CpuReset),
        .AccessFault(AccessFault),
        .MisalignFault(MisalignFault),
        .LoadDone(LoadDone)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: apply the rules to the inputs seen at each rising edge.
    initial begin
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
        m_run = 1'b0; m_wait_len = 1'b1; m_remaining = 0; m_ptr = 0; m_af = 0; m_mf = 0;
    end

    always @(posedge clk) begin
        if (Reset) begin
            m_run = 1'b0; m_wait_len = 1'b1; m_remaining = 0; m_ptr = 0;
            m_af = 1'b0; m_mf = 1'b0;
        end else if (!m_run) begin
            if (LoadValid) begin
                if (m_wait_len) begin
                    int n;
                    n = (LoadData > 64) ? 64 : int'(LoadData);
                    if (n == 0) m_run = 1'b1;
                    else begin
                        m_remaining = n;
                        m_wait_len = 1'b0;
                    end
                end else begin
                    m_mem[m_ptr] = LoadData;
                    m_known[m_ptr] = 1'b1;
                    m_ptr++;
                    m_remaining--;
                    if (m_remaining == 0) m_run = 1'b1;
                end
            end
        end else begin
            if (Adr >= 32'd256) m_af = 1'b1;
            if (Adr[1:0] != 2'b00) m_mf = 1'b1;
            if (MemWrite && Adr < 32'd256) begin
                m_mem[Adr[7:2]] = WriteData;
                m_known[Adr[7:2]] = 1'b1;
            end
        end
    end

    // Scoreboard compare: every cycle, just after inputs settle.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            logic [31:0] exp_q[$];
            chk("cpu_reset", {31'b0, CpuReset}, {31'b0, !m_run});
            chk("load_ready", {31'b0, LoadReady}, {31'b0, !m_run});
            chk("load_done", {31'b0, LoadDone}, {31'b0, m_run});
            chk("access_fault", {31'b0, AccessFault}, {31'b0, m_af});
            chk("misalign_fault", {31'b0, MisalignFault}, {31'b0, m_mf});
            if (Adr >= 32'd256) exp_q.push_back(32'h0);
            else if (m_known[Adr[7:2]]) exp_q.push_back(m_mem[Adr[7:2]]);
            if (exp_q.size() > 0) chk("read_data", ReadData, exp_q.pop_front());
        end
    end

    // Driver tasks: inputs change on the falling edge.
    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic lv, input logic [31:0] ld);
        @(negedge clk);
        Adr = a; MemWrite = we; WriteData = wd; LoadValid = lv; LoadData = ld;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        Adr = 32'h0; MemWrite = 1'b0; LoadValid = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    initial begin
        int hs;
        logic [31:0] old_word;
        Reset = 1'b1; Adr = 32'h0; WriteData = 32'h0; MemWrite = 1'b0;
        LoadValid = 1'b0; LoadData = 32'h0;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("rst_cpu_reset", {31'b0, CpuReset}, 32'd1);
        chk("rst_load_done", {31'b0, LoadDone}, 32'd0);

        // Three-word boot program.
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'd3);
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'hE3A00005);
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'hE2801001);
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'hEAFFFFFE);
        #2;
        chk("boot_last_cpu_reset", {31'b0, CpuReset}, 32'd1);
        chk("boot_last_done", {31'b0, LoadDone}, 32'd0);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("boot_done", {31'b0, LoadDone}, 32'd1);
        chk("boot_cpu_run", {31'b0, CpuReset}, 32'd0);
        chk("boot_rd0", ReadData, 32'hE3A00005);
        drive(32'h4, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 chk("boot_rd1", ReadData, 32'hE2801001);
        drive(32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 chk("boot_rd2", ReadData, 32'hEAFFFFFE);

        // Zero length: straight to RUN, memory untouched.
        do_reset();
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'd0);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("len0_done", {31'b0, LoadDone}, 32'd1);
        chk("len0_cpu_run", {31'b0, CpuReset}, 32'd0);
        chk("len0_mem", ReadData, 32'hE3A00005);

        // Oversized length clamps to 64 data handshakes, with random gaps.
        do_reset();
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'd200);
        hs = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (LoadDone) break;
            Adr = 32'($urandom_range(0, 63)) << 2;
            LoadValid = ($urandom_range(0, 3) != 0);
            LoadData = $urandom;
            #1;
            if (LoadValid && LoadReady) hs++;
        end
        chk("clamp_handshakes", 32'(hs), 32'd64);
        LoadValid = 1'b0;

        // Read-during-write returns old word, new word next cycle.
        drive(32'h10, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 old_word = m_mem[4];
        drive(32'h10, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        #2 chk("rdw_old", ReadData, old_word);
        drive(32'h10, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 chk("rdw_new", ReadData, 32'hDEADBEEF);

        // Out-of-range write is dropped and faults stick.
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 old_word = ReadData;
        drive(32'h100, 1'b1, 32'h12345678, 1'b0, 32'h0);
        #2 chk("oor_read_zero", ReadData, 32'h0);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("oor_fault", {31'b0, AccessFault}, 32'd1);
        chk("oor_word0_kept", ReadData, old_word);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 chk("oor_fault_sticky", {31'b0, AccessFault}, 32'd1);
        drive(32'h12, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("mis_read_word4", ReadData, 32'hDEADBEEF);
        chk("mis_not_yet", {31'b0, MisalignFault}, 32'd0);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 chk("mis_fault", {31'b0, MisalignFault}, 32'd1);

        // Random core traffic in RUN.
        for (int c = 0; c < 300; c++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0: a = $urandom;
                1: a = 32'($urandom_range(0, 255));
                default: a = 32'($urandom_range(0, 63)) << 2;
            endcase
            drive(a, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, $urandom);
        end

        // Reset in the middle of a load keeps the words already written.
        do_reset();
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'd5);
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'h11111111);
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'h22222222);
        @(negedge clk);
        Reset = 1'b1; LoadValid = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
        #2;
        chk("mid_rst_cpu_reset", {31'b0, CpuReset}, 32'd1);
        chk("mid_rst_af", {31'b0, AccessFault}, 32'd0);
        chk("mid_rst_mf", {31'b0, MisalignFault}, 32'd0);
        chk("mid_rst_word0", ReadData, 32'h11111111);
        drive(32'h4, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 chk("mid_rst_word1", ReadData, 32'h22222222);

        // A fresh load after the interrupted one, with random gaps.
        drive(32'h0, 1'b0, 32'h0, 1'b1, 32'd5);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (LoadDone) break;
            Adr = 32'($urandom_range(0, 7)) << 2;
            LoadValid = ($urandom_range(0, 1) == 1);
            LoadData = $urandom;
        end
        chk("reload_done", {31'b0, LoadDone}, 32'd1);
        LoadValid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(32'($urandom_range(0, 7)) << 2, 1'b0, 32'h0, 1'b0, 32'h0);
        end

        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
